// File: rtl/sample_strobe_tx_pkg.sv
// Shared types and widths for the strobed 10-bit sample transmitter.
// Contents:
//   SAMPLE_W / LO_W / HI_W  sample width and how it is split across the bus
//   sample_t                one sample
//   tx_state_t              transmit FSM states
package sample_tx_pkg;
    localparam int SAMPLE_W = 10;
    localparam int LO_W     = 8;
    localparam int HI_W     = 2;

    typedef logic [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STB_HI = 2'd1,
        STB_LO = 2'd2
    } tx_state_t;
endpackage

// File: rtl/sample_strobe_tx_if.sv
// Upstream valid/ready sample push channel.
//   s_data   sample to send (master -> slave)
//   s_valid  s_data valid   (master -> slave)
//   s_ready  slave can take a sample this cycle (slave -> master)
interface sample_strobe_tx_if;
    import sample_tx_pkg::*;
    sample_t s_data;
    logic    s_valid;
    logic    s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/sample_strobe_tx_fifo.sv
// Small synchronous sample FIFO. The head entry is read straight out of the
// storage registers, so a pop consumes the value visible in that cycle.
// Ports:
//   i_clk, i_rst  clock, synchronous active-high reset (pointers/level only)
//   i_push/i_data write one entry (ignored when full)
//   i_pop         drop the head entry (ignored when empty)
//   o_data        head entry
//   o_full/o_empty/o_level  occupancy
module sample_fifo
    import sample_tx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  sample_t                  i_data,
    input  logic                     i_pop,
    output sample_t                  o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    sample_t         r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [LW-1:0]   r_level;
    logic            w_push;
    logic            w_pop;

    assign o_full  = (r_level == LW'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_data  = r_mem[r_rptr];

    // No pass-through: a full FIFO refuses the push even if it pops this edge.
    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    // Storage is not reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end
endmodule

// File: rtl/sample_strobe_tx.sv
// Transmit side of the strobed 10-bit sample bus. Samples pushed through the
// valid/ready channel are buffered, then sent one per frame: data is loaded
// and the strobe raised for HI_CYC cycles, then dropped for LO_CYC cycles with
// data held. A waiting sample starts the next frame straight from STB_LO.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_ena          allow new frames to start (FIFO accepts regardless)
//   s_if           upstream push channel (slave side)
//   o_tx_lo/o_tx_hi/o_tx_stb  registered bus outputs
//   o_busy         FSM not idle
//   o_fifo_level   buffered samples
//   o_sent_count   frames started since reset, wrapping
module sample_strobe_tx
    import sample_tx_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int HI_CYC     = 1,
    parameter int LO_CYC     = 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_ena,
    sample_strobe_tx_if.slave             s_if,
    output logic [LO_W-1:0]               o_tx_lo,
    output logic [HI_W-1:0]               o_tx_hi,
    output logic                          o_tx_stb,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic [15:0]                   o_sent_count
);
    localparam int MAXC = (HI_CYC > LO_CYC) ? HI_CYC : LO_CYC;
    localparam int CW   = $clog2(MAXC) + 1;
    localparam logic [CW-1:0] HI_LAST = CW'(HI_CYC - 1);
    localparam logic [CW-1:0] LO_LAST = CW'(LO_CYC - 1);

    tx_state_t       r_state, w_nxt_state;
    logic [CW-1:0]   r_cnt, w_nxt_cnt;
    logic [LO_W-1:0] r_tx_lo;
    logic [HI_W-1:0] r_tx_hi;
    logic            r_tx_stb, w_nxt_stb;
    logic [15:0]     r_sent;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    sample_t         w_head;

    sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (s_if.s_valid),
        .i_data  (s_if.s_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (o_fifo_level)
    );

    assign s_if.s_ready = ~w_full;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_tx_stb <= 1'b0;
        end else begin
            r_state  <= w_nxt_state;
            r_cnt    <= w_nxt_cnt;
            r_tx_stb <= w_nxt_stb;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_stb   = r_tx_stb;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_ena && !w_empty) begin
                    w_pop       = 1'b1;
                    w_nxt_stb   = 1'b1;
                    w_nxt_cnt   = '0;
                    w_nxt_state = STB_HI;
                end
            end
            STB_HI: begin
                if (r_cnt == HI_LAST) begin
                    w_nxt_stb   = 1'b0;
                    w_nxt_cnt   = '0;
                    w_nxt_state = STB_LO;
                end else begin
                    w_nxt_cnt   = r_cnt + CW'(1);
                end
            end
            STB_LO: begin
                if (r_cnt == LO_LAST) begin
                    w_nxt_cnt = '0;
                    if (i_ena && !w_empty) begin
                        // back-to-back: next frame starts without an IDLE cycle
                        w_pop       = 1'b1;
                        w_nxt_stb   = 1'b1;
                        w_nxt_state = STB_HI;
                    end else begin
                        w_nxt_state = IDLE;
                    end
                end else begin
                    w_nxt_cnt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_nxt_state = IDLE;
                w_nxt_cnt   = '0;
                w_nxt_stb   = 1'b0;
            end
        endcase
    end

    // Data and frame count only move on a frame start, so data holds through
    // the whole frame and keeps its last value while idle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tx_lo <= '0;
            r_tx_hi <= '0;
            r_sent  <= '0;
        end else if (w_pop) begin
            r_tx_lo <= w_head[LO_W-1:0];
            r_tx_hi <= w_head[SAMPLE_W-1:LO_W];
            r_sent  <= r_sent + 16'd1;
        end
    end

    assign o_tx_lo      = r_tx_lo;
    assign o_tx_hi      = r_tx_hi;
    assign o_tx_stb     = r_tx_stb;
    assign o_busy       = (r_state != IDLE);
    assign o_sent_count = r_sent;
endmodule

// File: tb/tb_sample_strobe_tx.sv
module tb_sample_strobe_tx;
    import sample_tx_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ena = 1'b0;
    logic ena3 = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sample_strobe_tx_if sif ();
    sample_strobe_tx_if sif3 ();

    logic [7:0]  tx_lo, tx_lo3;
    logic [1:0]  tx_hi, tx_hi3;
    logic        tx_stb, tx_stb3, busy, busy3;
    logic [2:0]  level, level3;
    logic [15:0] sent, sent3;

    sample_strobe_tx dut (
        .i_clk(clk), .i_rst(rst), .i_ena(ena), .s_if(sif),
        .o_tx_lo(tx_lo), .o_tx_hi(tx_hi), .o_tx_stb(tx_stb), .o_busy(busy),
        .o_fifo_level(level), .o_sent_count(sent)
    );

    sample_strobe_tx #(.FIFO_DEPTH(4), .HI_CYC(3), .LO_CYC(2)) dut3 (
        .i_clk(clk), .i_rst(rst), .i_ena(ena3), .s_if(sif3),
        .o_tx_lo(tx_lo3), .o_tx_hi(tx_hi3), .o_tx_stb(tx_stb3), .o_busy(busy3),
        .o_fifo_level(level3), .o_sent_count(sent3)
    );

    // Strobe rising-edge capture models (what the receiver latches).
    sample_t cap[$];
    int      rise[$];
    logic    prev_stb = 1'b0;
    always @(negedge clk) begin
        if (tx_stb && !prev_stb) begin
            cap.push_back({tx_hi, tx_lo});
            rise.push_back(cyc);
        end
        prev_stb = tx_stb;
    end

    sample_t cap3[$];
    int      rise3[$];
    int      hl3[$];
    int      hcnt3 = 0;
    logic    prev_stb3 = 1'b0;
    always @(negedge clk) begin
        if (tx_stb3 && !prev_stb3) begin
            cap3.push_back({tx_hi3, tx_lo3});
            rise3.push_back(cyc);
        end
        if (tx_stb3) hcnt3++;
        else if (prev_stb3) begin
            hl3.push_back(hcnt3);
            hcnt3 = 0;
        end
        prev_stb3 = tx_stb3;
    end

    // Everything in the bench happens just after the falling edge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        sif.s_valid = 1'b0;
        sif3.s_valid = 1'b0;
        ena = 1'b0;
        ena3 = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        cap.delete(); rise.delete();
        cap3.delete(); rise3.delete(); hl3.delete();
    endtask

    task automatic test_reset();
        sif.s_valid = 1'b0; sif.s_data = '0;
        sif3.s_valid = 1'b0; sif3.s_data = '0;
        rst = 1'b1;
        step();
        step();
        checks++; if (tx_lo !== 8'h00) begin failures++; $display("FAIL reset_tx_lo got=%h exp=00", tx_lo); end
        checks++; if (tx_hi !== 2'b00) begin failures++; $display("FAIL reset_tx_hi got=%b exp=00", tx_hi); end
        checks++; if (tx_stb !== 1'b0) begin failures++; $display("FAIL reset_tx_stb got=%b exp=0", tx_stb); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (sif.s_ready !== 1'b1) begin failures++; $display("FAIL reset_s_ready got=%b exp=1", sif.s_ready); end
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (sent !== 16'd0) begin failures++; $display("FAIL reset_sent got=%0d exp=0", sent); end
        rst = 1'b0;
        cap.delete(); rise.delete();
    endtask

    task automatic test_single();
        do_reset();
        ena = 1'b1;
        sif.s_data = 10'h2A5;
        sif.s_valid = 1'b1;
        step();                       // push edge k
        sif.s_valid = 1'b0;
        checks++; if (tx_stb !== 1'b0 || level !== 3'd1) begin failures++; $display("FAIL single_after_push stb=%b level=%0d exp stb=0 level=1", tx_stb, level); end
        step();                       // edge k+1: frame start
        checks++; if (tx_stb !== 1'b1 || tx_hi !== 2'b10 || tx_lo !== 8'hA5) begin failures++; $display("FAIL single_start stb=%b hi=%b lo=%h exp 1 10 a5", tx_stb, tx_hi, tx_lo); end
        checks++; if (sent !== 16'd1 || busy !== 1'b1 || level !== 3'd0) begin failures++; $display("FAIL single_start_status sent=%0d busy=%b level=%0d exp 1 1 0", sent, busy, level); end
        step();
        checks++; if (tx_stb !== 1'b0 || tx_hi !== 2'b10 || tx_lo !== 8'hA5 || busy !== 1'b1) begin failures++; $display("FAIL single_low stb=%b hi=%b lo=%h busy=%b exp 0 10 a5 1", tx_stb, tx_hi, tx_lo, busy); end
        step();
        checks++; if (busy !== 1'b0 || tx_stb !== 1'b0 || tx_lo !== 8'hA5 || tx_hi !== 2'b10) begin failures++; $display("FAIL single_idle busy=%b stb=%b hi=%b lo=%h exp 0 0 10 a5", busy, tx_stb, tx_hi, tx_lo); end
        checks++; if (cap.size() != 1) begin failures++; $display("FAIL single_strobes got=%0d exp=1", cap.size()); end
    endtask

    task automatic test_stream();
        int   i = 0;
        int   guard = 0;
        bit   saw_full = 0;
        bit   rdy;
        int   bad_idx;
        int   bad_per;
        do_reset();
        ena = 1'b1;
        sif.s_valid = 1'b1;
        while (i < 1000 && guard < 20000) begin
            sif.s_data = sample_t'(i);
            rdy = sif.s_ready;
            if (!rdy) saw_full = 1;
            step();
            if (rdy) i++;
            guard++;
        end
        sif.s_valid = 1'b0;
        guard = 0;
        while ((busy || level != 0) && guard < 100) begin step(); guard++; end
        checks++; if (i != 1000) begin failures++; $display("FAIL stream_push_timeout pushed=%0d exp=1000", i); end
        checks++; if (!saw_full) begin failures++; $display("FAIL stream_backpressure saw_not_ready=0 exp=1"); end
        checks++; if (cap.size() != 1000) begin failures++; $display("FAIL stream_count got=%0d exp=1000", cap.size()); end
        bad_idx = -1;
        foreach (cap[k]) if (bad_idx < 0 && cap[k] !== sample_t'(k)) bad_idx = k;
        checks++; if (bad_idx >= 0) begin failures++; $display("FAIL stream_order idx=%0d got=%0d exp=%0d", bad_idx, cap[bad_idx], bad_idx); end
        bad_per = 0;
        for (int k = 1; k < rise.size(); k++) if (bad_per == 0 && rise[k] - rise[k-1] != 2) bad_per = rise[k] - rise[k-1];
        checks++; if (bad_per != 0) begin failures++; $display("FAIL stream_period got=%0d exp=2", bad_per); end
        checks++; if (sent !== 16'd1000) begin failures++; $display("FAIL stream_sent got=%0d exp=1000", sent); end
    endtask

    task automatic test_back_to_back();
        int gaps = 0;
        bit seen4 = 0;
        int bad_per = 0;
        do_reset();
        sif.s_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sif.s_data = 10'h3F0 + 10'(k);
            step();
        end
        sif.s_data = 10'h155;         // offered while full: must be refused
        step();
        sif.s_valid = 1'b0;
        checks++; if (level !== 3'd4) begin failures++; $display("FAIL b2b_level_full got=%0d exp=4", level); end
        checks++; if (sif.s_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_full got=%b exp=0", sif.s_ready); end
        checks++; if (cap.size() != 0 || busy !== 1'b0) begin failures++; $display("FAIL b2b_held_off strobes=%0d busy=%b exp 0 0", cap.size(), busy); end
        ena = 1'b1;
        for (int n = 0; n < 20; n++) begin
            step();
            if (cap.size() >= 1 && !seen4 && !busy) gaps++;
            if (cap.size() == 4) seen4 = 1;
        end
        checks++; if (gaps != 0) begin failures++; $display("FAIL b2b_idle_gap got=%0d exp=0", gaps); end
        checks++; if (cap.size() != 4) begin failures++; $display("FAIL b2b_frames got=%0d exp=4", cap.size()); end
        else begin
            checks++; if (cap[0] !== 10'h3F0 || cap[1] !== 10'h3F1 || cap[2] !== 10'h3F2 || cap[3] !== 10'h3F3) begin failures++; $display("FAIL b2b_data got=%h %h %h %h exp=3f0 3f1 3f2 3f3", cap[0], cap[1], cap[2], cap[3]); end
            for (int k = 1; k < 4; k++) if (rise[k] - rise[k-1] != 2) bad_per = rise[k] - rise[k-1];
            checks++; if (bad_per != 0) begin failures++; $display("FAIL b2b_period got=%0d exp=2", bad_per); end
        end
        checks++; if (level !== 3'd0 || sent !== 16'd4 || busy !== 1'b0) begin failures++; $display("FAIL b2b_end level=%0d sent=%0d busy=%b exp 0 4 0", level, sent, busy); end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        sif.s_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sif.s_data = 10'h0A0 + 10'(k);
            step();
        end
        sif.s_valid = 1'b0;
        ena = 1'b1;
        step();
        checks++; if (tx_stb !== 1'b1 || level !== 3'd3) begin failures++; $display("FAIL midrst_pre stb=%b level=%0d exp 1 3", tx_stb, level); end
        rst = 1'b1;
        step();
        checks++; if (tx_stb !== 1'b0 || level !== 3'd0 || sent !== 16'd0) begin failures++; $display("FAIL midrst_clear stb=%b level=%0d sent=%0d exp 0 0 0", tx_stb, level, sent); end
        checks++; if (busy !== 1'b0 || sif.s_ready !== 1'b1 || tx_lo !== 8'h00 || tx_hi !== 2'b00) begin failures++; $display("FAIL midrst_state busy=%b ready=%b lo=%h hi=%b exp 0 1 00 00", busy, sif.s_ready, tx_lo, tx_hi); end
        rst = 1'b0;
        for (int n = 0; n < 10; n++) step();
        checks++; if (cap.size() != 1 || sent !== 16'd0) begin failures++; $display("FAIL midrst_no_resume strobes=%0d sent=%0d exp 1 0", cap.size(), sent); end
    endtask

    task automatic test_slow_timing();
        int guard = 0;
        do_reset();
        sif3.s_valid = 1'b1;
        sif3.s_data = 10'h011; step();
        sif3.s_data = 10'h022; step();
        sif3.s_data = 10'h033; step();
        sif3.s_valid = 1'b0;
        ena3 = 1'b1;
        while (cap3.size() < 2 && guard < 30) begin step(); guard++; end
        checks++; if (cap3.size() != 2) begin failures++; $display("FAIL slow_two_frames_timeout got=%0d exp=2", cap3.size()); end
        ena3 = 1'b0;                  // dropped during frame 2's high phase
        for (int n = 0; n < 15; n++) step();
        checks++; if (cap3.size() != 2 || tx_stb3 !== 1'b0 || busy3 !== 1'b0 || level3 !== 3'd1) begin failures++; $display("FAIL slow_hold strobes=%0d stb=%b busy=%b level=%0d exp 2 0 0 1", cap3.size(), tx_stb3, busy3, level3); end
        checks++; if (hl3.size() != 2 || (hl3.size() == 2 && (hl3[0] != 3 || hl3[1] != 3))) begin failures++; $display("FAIL slow_high_len frames=%0d exp 2 frames of 3 cycles", hl3.size()); end
        checks++; if (rise3.size() == 2 && rise3[1] - rise3[0] != 5) begin failures++; $display("FAIL slow_period got=%0d exp=5", rise3[1] - rise3[0]); end
        ena3 = 1'b1;
        guard = 0;
        while (hl3.size() < 3 && guard < 30) begin step(); guard++; end
        checks++; if (cap3.size() != 3 || hl3.size() != 3) begin failures++; $display("FAIL slow_resume_timeout strobes=%0d highs=%0d exp 3 3", cap3.size(), hl3.size()); end
        else begin
            checks++; if (cap3[0] !== 10'h011 || cap3[1] !== 10'h022 || cap3[2] !== 10'h033) begin failures++; $display("FAIL slow_data got=%h %h %h exp=011 022 033", cap3[0], cap3[1], cap3[2]); end
            checks++; if (hl3[2] != 3) begin failures++; $display("FAIL slow_high_len3 got=%0d exp=3", hl3[2]); end
        end
        checks++; if (sent3 !== 16'd3 || level3 !== 3'd0) begin failures++; $display("FAIL slow_end sent=%0d level=%0d exp 3 0", sent3, level3); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_back_to_back();
        test_reset_mid_frame();
        test_slow_timing();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
